// File: rtl/imm_arith_decoder.sv
// imm_arith_decoder: sequenced immediate-class decoder.
// Turns one 32-bit instruction into one or two registered 31-bit control words
// (ADD/SUB immediate, and MOVZ/MOVK when move-wide support is compiled in).
// Optional feature macro: IMM_ARITH_MOVE_WIDE_EN enables MOVZ/MOVK and the MOVK2 state.
module imm_arith_decoder #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instruction,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [30:0]           controlWord,
    output logic [DATA_WIDTH-1:0] K,
    output logic [1:0]            nextState,
    output logic                  cw_valid,
    output logic                  illegal
);

    localparam logic [4:0] FSEL_ADD = 5'b01000;
`ifdef IMM_ARITH_MOVE_WIDE_EN
    localparam logic [4:0] FSEL_AND = 5'b00000;
    localparam logic [4:0] FSEL_OR  = 5'b00100;

    typedef enum logic {S_IDLE = 1'b0, S_MOVK2 = 1'b1} state_t;
    state_t r_state;
`endif

    // Control word layout:
    // {Psel, DA, SA, SB, Fsel, regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, Bsel, PCsel, SL}
    // Every legal word writes a register through the ALU with B taken from K.
    function automatic logic [30:0] pack_cw(input logic [1:0] psel, input logic [4:0] da,
                                            input logic [4:0] sa, input logic [4:0] fsel,
                                            input logic sl);
        pack_cw = {psel, da, sa, 5'd31, fsel,
                   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, sl};
    endfunction

    // Instruction fields
    logic [4:0]            w_da;
    logic [4:0]            w_sa;
    logic [11:0]           w_imm12;
    logic                  w_sf_ok;
    logic                  w_cls_addsub;
    logic [DATA_WIDTH-1:0] w_k_addsub;

    // First (or only) word produced on accept
    logic                  w_legal;
    logic [30:0]           w_cw1;
    logic [DATA_WIDTH-1:0] w_k1;
    logic [1:0]            w_ns1;

`ifdef IMM_ARITH_MOVE_WIDE_EN
    logic                  w_cls_movew;
    logic [1:0]            w_opc;
    logic [1:0]            w_hw;
    logic [15:0]           w_imm16;
    logic [5:0]            w_shamt;
    logic                  w_hw_bad;
    logic [DATA_WIDTH-1:0] w_k_mov;
    logic [DATA_WIDTH-1:0] w_k_mask;
    logic                  w_two;
    logic [30:0]           w_cw2;
    logic [DATA_WIDTH-1:0] w_k2;
    logic [30:0]           r_cw2;
    logic [DATA_WIDTH-1:0] r_k2;
`endif

    assign w_da         = instruction[4:0];
    assign w_sa         = instruction[9:5];
    assign w_imm12      = instruction[21:10];
    assign w_sf_ok      = (instruction[31] == (DATA_WIDTH == 64));
    assign w_cls_addsub = (instruction[28:23] == 6'b100010);
    assign w_k_addsub   = instruction[22] ? (DATA_WIDTH'(w_imm12) << 12) : DATA_WIDTH'(w_imm12);

`ifdef IMM_ARITH_MOVE_WIDE_EN
    assign w_cls_movew = (instruction[28:23] == 6'b100101);
    assign w_opc       = instruction[30:29];
    assign w_hw        = instruction[22:21];
    assign w_imm16     = instruction[20:5];
    assign w_shamt     = {w_hw, 4'b0000};
    // A half-word slot beyond the datapath width cannot be addressed
    assign w_hw_bad    = (DATA_WIDTH == 32) && w_hw[1];
    assign w_k_mov     = DATA_WIDTH'(w_imm16) << w_shamt;
    assign w_k_mask    = ~(DATA_WIDTH'(16'hFFFF) << w_shamt);
    assign instr_ready = (r_state == S_IDLE);
`else
    assign instr_ready = 1'b1;
`endif

    // Decode the presented instruction into the word(s) to emit on accept
    always_comb begin
        w_legal = 1'b0;
        w_cw1   = pack_cw(2'b01, w_da, w_sa, {4'b0100, instruction[30]}, instruction[29]);
        w_k1    = w_k_addsub;
        w_ns1   = 2'b00;
`ifdef IMM_ARITH_MOVE_WIDE_EN
        w_two   = 1'b0;
        w_cw2   = pack_cw(2'b01, w_da, w_da, FSEL_OR, 1'b0);
        w_k2    = w_k_mov;
`endif
        if (w_cls_addsub) begin
            w_legal = w_sf_ok;
        end
`ifdef IMM_ARITH_MOVE_WIDE_EN
        else if (w_cls_movew) begin
            if (w_opc == 2'b10) begin
                // MOVZ: Rd = XZR + imm16 placed in its half-word slot
                w_legal = w_sf_ok && !w_hw_bad;
                w_cw1   = pack_cw(2'b01, w_da, 5'd31, FSEL_ADD, 1'b0);
                w_k1    = w_k_mov;
            end else if (w_opc == 2'b11) begin
                // MOVK: clear the slot with AND, then OR the new half-word in
                w_legal = w_sf_ok && !w_hw_bad;
                w_two   = 1'b1;
                w_cw1   = pack_cw(2'b00, w_da, w_da, FSEL_AND, 1'b0);
                w_k1    = w_k_mask;
                w_ns1   = 2'b01;
            end
        end
`endif
    end

    // Sequencer: registers every output and holds MOVK word 2 for the following cycle
    always_ff @(posedge clock) begin
        if (reset) begin
`ifdef IMM_ARITH_MOVE_WIDE_EN
            r_state <= S_IDLE;
`endif
            controlWord <= '0;
            K           <= '0;
            nextState   <= 2'b00;
            cw_valid    <= 1'b0;
            illegal     <= 1'b0;
        end
`ifdef IMM_ARITH_MOVE_WIDE_EN
        else if (r_state == S_MOVK2) begin
            controlWord <= r_cw2;
            K           <= r_k2;
            nextState   <= 2'b00;
            cw_valid    <= 1'b1;
            illegal     <= 1'b0;
            r_state     <= S_IDLE;
        end
`endif
        else if (instr_valid) begin
            if (w_legal) begin
                controlWord <= w_cw1;
                K           <= w_k1;
                nextState   <= w_ns1;
                cw_valid    <= 1'b1;
                illegal     <= 1'b0;
`ifdef IMM_ARITH_MOVE_WIDE_EN
                if (w_two) begin
                    r_state <= S_MOVK2;
                    r_cw2   <= w_cw2;
                    r_k2    <= w_k2;
                end
`endif
            end else begin
                controlWord <= '0;
                K           <= '0;
                nextState   <= 2'b00;
                cw_valid    <= 1'b0;
                illegal     <= 1'b1;
            end
        end else begin
            cw_valid <= 1'b0;
            illegal  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_arith_decoder.sv
// Bench for imm_arith_decoder: a 64-bit and a 32-bit instance share stimulus;
// a behavioural model pushes the expected output of every cycle into a queue,
// which is popped and compared after the clock edge.
module tb_imm_arith_decoder;

`ifdef IMM_ARITH_MOVE_WIDE_EN
    localparam bit MW_EN = 1'b1;
`else
    localparam bit MW_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instruction;

    logic        rdy64, rdy32;
    logic [30:0] cw64, cw32;
    logic [63:0] k64;
    logic [31:0] k32;
    logic [1:0]  ns64, ns32;
    logic        v64, v32, il64, il32;

    always #5 clock = ~clock;

    imm_arith_decoder #(.DATA_WIDTH(64)) u_dut64 (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(rdy64), .controlWord(cw64), .K(k64), .nextState(ns64),
        .cw_valid(v64), .illegal(il64)
    );

    imm_arith_decoder #(.DATA_WIDTH(32)) u_dut32 (
        .clock(clock), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(rdy32), .controlWord(cw32), .K(k32), .nextState(ns32),
        .cw_valid(v32), .illegal(il32)
    );

    typedef struct {
        logic [30:0] cw;
        logic [63:0] k;
        logic [1:0]  ns;
        logic        vld;
        logic        ill;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];
    bit   busy[2];
    exp_t pend[2];
    exp_t last[2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [30:0] mk_cw(input logic [1:0] psel, input logic [4:0] da,
                                          input logic [4:0] sa, input logic [4:0] fsel,
                                          input logic sl);
        // Psel, DA, SA, SB=31, Fsel, regW=1, ramW=0, EN_MEM=0, EN_ALU=1, EN_B=0,
        // EN_PC=0, Bsel=1, PCsel=0, SL
        return {psel, da, sa, 5'd31, fsel, 9'b100100100} | {30'b0, sl};
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.cw = '0; e.k = '0; e.ns = 2'b00; e.vld = 1'b0; e.ill = 1'b0;
        return e;
    endfunction

    // Expected behaviour of one instance for the coming clock edge
    task automatic model_step(input int idx, input int dw, input logic v,
                              input logic [31:0] ins, input logic rst);
        exp_t        e, w1;
        logic [63:0] wmask, kmov;
        bit          legal, two, sf_ok;
        int          sh;
        e     = zero_exp();
        w1    = zero_exp();
        wmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        sf_ok = (ins[31] == (dw == 64));
        sh    = 16 * int'(ins[22:21]);
        legal = 1'b0;
        two   = 1'b0;
        kmov  = (64'(ins[20:5]) << sh) & wmask;
        if (ins[28:23] == 6'b100010 && sf_ok) begin
            legal = 1'b1;
            w1.cw = mk_cw(2'b01, ins[4:0], ins[9:5], {4'b0100, ins[30]}, ins[29]);
            w1.k  = ins[22] ? (64'(ins[21:10]) << 12) : 64'(ins[21:10]);
        end else if (MW_EN && ins[28:23] == 6'b100101 && sf_ok && ins[30] && sh < dw) begin
            legal = 1'b1;
            if (!ins[29]) begin
                w1.cw = mk_cw(2'b01, ins[4:0], 5'd31, 5'b01000, 1'b0);
                w1.k  = kmov;
            end else begin
                two   = 1'b1;
                w1.cw = mk_cw(2'b00, ins[4:0], ins[4:0], 5'b00000, 1'b0);
                w1.k  = ~(64'hFFFF << sh) & wmask;
                w1.ns = 2'b01;
                pend[idx]     = zero_exp();
                pend[idx].cw  = mk_cw(2'b01, ins[4:0], ins[4:0], 5'b00100, 1'b0);
                pend[idx].k   = kmov;
                pend[idx].vld = 1'b1;
            end
        end
        w1.vld = 1'b1;

        if (rst) begin
            busy[idx] = 1'b0;
            last[idx] = e;
        end else if (busy[idx]) begin
            e = pend[idx];
            busy[idx] = 1'b0;
            last[idx] = e;
        end else if (v) begin
            if (legal) begin
                e = w1;
                busy[idx] = two;
            end else begin
                e.ill = 1'b1;
            end
            last[idx] = e;
        end else begin
            e = last[idx];
            e.vld = 1'b0;
            e.ill = 1'b0;
        end
        if (idx == 0) q64.push_back(e);
        else          q32.push_back(e);
    endtask

    // One clock cycle: drive, check ready, predict, then compare after the edge
    task automatic cyc(input logic v, input logic [31:0] ins, input logic rst);
        exp_t e;
        reset       = rst;
        instr_valid = v;
        instruction = ins;
        check_eq("ready64", 64'(rdy64), 64'(!busy[0]));
        check_eq("ready32", 64'(rdy32), 64'(!busy[1]));
        model_step(0, 64, v, ins, rst);
        model_step(1, 32, v, ins, rst);
        @(posedge clock);
        #1;
        e = q64.pop_front();
        check_eq("cw64",  64'(cw64), 64'(e.cw));
        check_eq("k64",   k64,       e.k);
        check_eq("ns64",  64'(ns64), 64'(e.ns));
        check_eq("vld64", 64'(v64),  64'(e.vld));
        check_eq("ill64", 64'(il64), 64'(e.ill));
        e = q32.pop_front();
        check_eq("cw32",  64'(cw32), 64'(e.cw));
        check_eq("k32",   64'(k32),  e.k);
        check_eq("ns32",  64'(ns32), 64'(e.ns));
        check_eq("vld32", 64'(v32),  64'(e.vld));
        check_eq("ill32", 64'(il32), 64'(e.ill));
    endtask

    localparam logic [31:0] ADDI   = 32'h9100_1441; // ADDI X1,X2,#5
    localparam logic [31:0] SUBIS  = 32'hF140_0483; // SUBIS X3,X4,#1,LSL#12
    localparam logic [31:0] MOVK   = 32'hF2B7_DDE5; // MOVK X5,#0xBEEF,LSL#16
    localparam logic [31:0] MOVN   = 32'h9280_0000;
    localparam logic [31:0] ADDIW  = 32'h1100_1441; // ADDI W1,W2,#5 (sf=0)
    localparam logic [31:0] MOVZW2 = 32'h52C0_0020; // MOVZ W0,#1,LSL#32 (hw=2, sf=0)
    localparam logic [31:0] MOVKW  = 32'h72A0_0005; // MOVK W5,#0,LSL#16
    localparam logic [31:0] MOVZ   = 32'hD280_0020; // MOVZ X0,#1

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r, ins;
        busy[0] = 1'b0; busy[1] = 1'b0;
        last[0] = zero_exp(); last[1] = zero_exp();
        pend[0] = zero_exp(); pend[1] = zero_exp();
        reset = 1'b1; instr_valid = 1'b0; instruction = '0;
        repeat (2) @(posedge clock);
        #1;

        cyc(1'b0, 32'h0, 1'b1);          // reset values
        cyc(1'b1, ADDI, 1'b0);
        cyc(1'b1, SUBIS, 1'b0);
        cyc(1'b1, MOVK, 1'b0);
        cyc(1'b1, ADDI, 1'b0);           // ignored by the 64-bit unit while in MOVK2
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, MOVN, 1'b0);
        cyc(1'b1, ADDIW, 1'b0);
        cyc(1'b1, MOVZW2, 1'b0);
        cyc(1'b1, MOVKW, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, MOVZ, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, MOVK, 1'b0);
        cyc(1'b1, ADDI, 1'b1);           // reset while in MOVK2
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, MOVKW, 1'b0);
        cyc(1'b1, MOVKW, 1'b0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom;
            case ($urandom_range(0, 2))
                0:       ins = {r[31], r[30], r[29], 6'b100010, r[22], r[21:10], r[9:5], r[4:0]};
                1:       ins = {r[31], r[30:29], 6'b100101, r[22:21], r[20:5], r[4:0]};
                default: ins = r;
            endcase
            cyc($urandom_range(0, 3) != 0, ins, $urandom_range(0, 29) == 0);
        end
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_arith_decoder.md
# imm_arith_decoder

Sequenced immediate-class decoder that turns one 32-bit instruction into one or two registered 31-bit control words for the datapath. It covers add/sub immediate (ADDI/ADDIS/SUBI/SUBIS, with the LSL #12 `sh` option) and move-wide (MOVZ, and MOVK in two steps), at a parameterised data width. It sits between the fetch/instruction register and the control-word mux, in place of the single-cycle I-arithmetic decoder.

## Interface
- `DATA_WIDTH`, default 64. Datapath and `K` width. Legal values: 32 or 64.
- `clock`  in  1  Single clock; all state changes on the rising edge.
- `reset`  in  1  Synchronous, active-high.
- `instruction`  in  32  Instruction word. Sampled only on accept.
- `instr_valid`  in  1  `instruction` is presented.
- `instr_ready`  out  1  Decoder can accept. Combinational: high exactly when the state is IDLE.
- `controlWord`  out  31  Registered. Layout: {Psel[1:0], DA[4:0], SA[4:0], SB[4:0], Fsel[4:0], regW, ramW, EN_MEM, EN_ALU, EN_B, EN_PC, Bsel, PCsel, SL}.
- `K`  out  DATA_WIDTH  Registered immediate or mask. Valid with `cw_valid`.
- `nextState`  out  2  Registered. 2'b01 = another word follows; 2'b00 = last word.
- `cw_valid`  out  1  Registered, one-cycle pulse per emitted control word.
- `illegal`  out  1  Registered, one-cycle pulse when an accepted word is unsupported.

## Operation
- Accept when `instr_valid && instr_ready`.
- States:
  - IDLE → IDLE for a single-word instruction.
  - IDLE → MOVK2 on accepting a legal MOVK.
  - MOVK2 → IDLE unconditionally.
- Opcode classes:
  - Add/sub immediate: `instruction[28:23]==6'b100010`.
  - Move-wide: `instruction[28:23]==6'b100101`.
  - Any other value sets `illegal`.
- `sf` rule: `instruction[31]` must equal (DATA_WIDTH==64); otherwise `illegal`.
- Common fields for every legal word:
  - DA = `instruction[4:0]`.
  - SB = 5'd31.
  - Bsel = 1, regW = 1, EN_ALU = 1.
  - ramW, EN_MEM, EN_B, EN_PC, PCsel all 0.
- Fsel codes: ADD 5'b01000, SUB 5'b01001, AND 5'b00000, OR 5'b00100.
- Add/sub immediate:
  - SA = `instruction[9:5]`.
  - Fsel = {4'b0100, `instruction[30]`}.
  - SL = `instruction[29]`.
  - K = zero-extended imm12 (`instruction[21:10]`), shifted left 12 when `instruction[22]`=1.
  - Psel = 2'b01, nextState = 2'b00.
- Move-wide fields: opc = `instruction[30:29]`, hw = `instruction[22:21]`, imm16 = `instruction[20:5]`, SL = 0.
  - opc 00 (MOVN) and opc 01: `illegal`.
  - hw*16 ≥ DATA_WIDTH: `illegal`.
- MOVZ (opc 10), one word:
  - SA = 5'd31 (XZR), Fsel = ADD, K = imm16<<(16*hw).
  - Psel = 2'b01, nextState = 2'b00.
- MOVK (opc 11), two words:
  - Word 1 (emitted on accept): SA = DA, Fsel = AND, K = ~(16'hFFFF<<(16*hw)) truncated to DATA_WIDTH, Psel = 2'b00 (hold PC), nextState = 2'b01.
  - Word 2 (emitted from MOVK2): SA = DA, Fsel = OR, K = imm16<<(16*hw), Psel = 2'b01, nextState = 2'b00.
  - Fields from the accepted instruction are held internally for word 2.
- Illegal accept:
  - `illegal` pulses and `cw_valid` stays low.
  - `controlWord` and `K` are driven to 0, so regW = 0.
  - State stays IDLE.

## Timing
- Reset value of every output: `controlWord` = 0, `K` = 0, `nextState` = 0, `cw_valid` = 0, `illegal` = 0.
- Reset puts the state in IDLE, so `instr_ready` = 1 from the first cycle after reset.
- Latency: an accept at edge N makes `controlWord`/`K`/`cw_valid` visible after edge N.
- MOVK word 2 appears after edge N+1.
- `instr_ready` is low for exactly one cycle after a MOVK accept.
- Back-to-back single-word instructions sustain one word per cycle.
- A cycle with no accept and state IDLE clears `cw_valid` and `illegal` to 0. `controlWord` and `K` hold their previous values.
- `instr_valid` while `instr_ready` = 0 is ignored, not queued.
- Reset asserted in MOVK2: word 2 is abandoned, state returns to IDLE, all outputs return to their reset values.

## Configuration
- `IMM_ARITH_MOVE_WIDE_EN` defined: MOVZ/MOVK decode and the MOVK2 state are compiled in.
- Undefined:
  - Every move-wide encoding raises `illegal`.
  - The state machine reduces to IDLE only.
  - `instr_ready` is constant 1.

## Test plan
- ADDI X1,X2,#5 (0x91001441), DATA_WIDTH=64 → one pulse: DA=1, SA=2, SB=31, Fsel=01000, SL=0, K=5, Psel=01, nextState=00.
- SUBIS X3,X4,#1,LSL#12 (0xF1400483) → Fsel=01001, SL=1, K=0x1000, regW=1.
- MOVK X5,#0xBEEF,LSL#16 (0xF2B7DDE5) →
  - Word 1: Fsel=00000, SA=DA=5, K=0xFFFFFFFF0000FFFF, Psel=00, nextState=01.
  - Word 2 next cycle: Fsel=00100, K=0x00000000BEEF0000, Psel=01.
  - `instr_ready` low for one cycle in between.
- Illegal encodings → `illegal` pulse, `cw_valid`=0, `controlWord`=0:
  - MOVN 0x92800000.
  - ADDI with sf=0 at DATA_WIDTH=64.
  - MOVZ hw=2 at DATA_WIDTH=32.
- Accept MOVK, assert `reset` in MOVK2 → no word 2, all outputs 0, `instr_ready`=1 the following cycle.
- Build without `IMM_ARITH_MOVE_WIDE_EN`: MOVZ 0xD2800020 → `illegal`; ADDI 0x91001441 is still decoded normally.
